// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register of the 5-stage MIPS pipeline.
//
// Purpose:
//   This module latches the decoded instruction, the PC+4 value, the two register
//   operands and the extended immediate coming out of ID. It decodes the
//   destination register that the forwarding logic compares against. It also
//   detects load-use hazards and inserts a one-cycle bubble when it finds one.
//   External hold (freeze) and flush (squash) requests are honoured.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   if_id_inst/pc    instruction and PC+4 currently in ID
//   rs_data/rt_data  register-file read data for rs / rt
//   hold             freeze: every register keeps its value
//   flush            squash: ID/EX becomes a bubble
//   ID_EX_inst, Rd_ID_EX, id_ex_pc, id_ex_rs_data, id_ex_rt_data,
//   id_ex_imm, id_ex_valid     registered stage contents
//   load_use_stall   combinational; upstream holds PC and IF/ID this cycle
//
// Optional build macro ID_EX_PERF_CNT_EN adds two saturating counters:
//   bubble_cnt       edges where a load-use or flush bubble was loaded
//   hold_cnt         edges where hold froze the register
module id_ex_stage #(
  parameter logic [31:0] NOP_INST = 32'h00000000,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_inst,
  input  logic [31:0] if_id_pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hold,
  input  logic        flush,
  output logic [31:0] ID_EX_inst,
  output logic [4:0]  Rd_ID_EX,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [31:0] id_ex_imm,
  output logic        id_ex_valid,
  output logic        load_use_stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] hold_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic        valid;
  } stage_t;

  stage_t stage_q, stage_d, load_s, bubble_s;

  // A destination of 0 means "no write", so forwarding never matches $0.
  function automatic logic [4:0] dec_rd(input logic [31:0] i);
    case (i[31:26])
      OP_RTYPE: dec_rd = (i[5:0] == FN_JR) ? 5'd0 : i[15:11];
      OP_LW, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LUI: dec_rd = i[20:16];
      OP_JAL:   dec_rd = LINK_REG;
      default:  dec_rd = 5'd0;
    endcase
  endfunction

  // Logical immediates are zero-extended. Everything else is sign-extended.
  // The lui shift is left to EX.
  function automatic logic [31:0] dec_imm(input logic [31:0] i);
    if (i[31:26] == OP_ANDI || i[31:26] == OP_ORI)
      dec_imm = {16'h0000, i[15:0]};
    else
      dec_imm = {{16{i[15]}}, i[15:0]};
  endfunction

  // Only R-type, sw, beq and bne consume rt as a source. For I-type
  // instructions rt is the destination, so it cannot create a hazard.
  logic id_reads_rt;
  assign id_reads_rt = (if_id_inst[31:26] == OP_RTYPE) || (if_id_inst[31:26] == OP_SW) ||
                       (if_id_inst[31:26] == OP_BEQ)   || (if_id_inst[31:26] == OP_BNE);

  // Stall while a valid lw in EX targets a register that the ID instruction
  // reads. The bubble clears valid, so the stall lasts one cycle unless hold
  // freezes the register.
  assign load_use_stall = stage_q.valid && (stage_q.inst[31:26] == OP_LW) &&
                          (stage_q.rd != 5'd0) &&
                          ((stage_q.rd == if_id_inst[25:21]) ||
                           (id_reads_rt && (stage_q.rd == if_id_inst[20:16])));

  always_comb begin
    bubble_s       = '0;
    bubble_s.inst  = NOP_INST;

    load_s.inst    = if_id_inst;
    load_s.rd      = dec_rd(if_id_inst);
    load_s.pc      = if_id_pc;
    load_s.rs      = rs_data;
    load_s.rt      = rt_data;
    load_s.imm     = dec_imm(if_id_inst);
    load_s.valid   = 1'b1;

    stage_d = stage_q;
    if (flush)               stage_d = bubble_s;
    else if (hold)           stage_d = stage_q;
    else if (load_use_stall) stage_d = bubble_s;
    else                     stage_d = load_s;
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= bubble_s;
    else     stage_q <= stage_d;
  end

  assign ID_EX_inst    = stage_q.inst;
  assign Rd_ID_EX      = stage_q.rd;
  assign id_ex_pc      = stage_q.pc;
  assign id_ex_rs_data = stage_q.rs;
  assign id_ex_rt_data = stage_q.rt;
  assign id_ex_imm     = stage_q.imm;
  assign id_ex_valid   = stage_q.valid;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d, hold_cnt_q, hold_cnt_d;
  logic        bubble_ev, hold_ev;

  // These events mirror the priority used for stage_d: a flush wins over
  // hold, and hold wins over a load-use bubble.
  assign bubble_ev = flush || (!hold && load_use_stall);
  assign hold_ev   = !flush && hold;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if (bubble_ev && bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (hold_ev && hold_cnt_q != '1)     hold_cnt_d   = hold_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, hold, flush;
  logic [31:0] if_id_inst, if_id_pc, rs_data, rt_data;
  logic [31:0] ID_EX_inst, id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]  Rd_ID_EX;
  logic        id_ex_valid, load_use_stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt, hold_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  localparam logic [31:0] ADD_3_1_2   = 32'h00221820;
  localparam logic [31:0] ADDI_5_0_M1 = 32'h2005FFFF;
  localparam logic [31:0] ORI_6_0_FF  = 32'h3406FFFF;
  localparam logic [31:0] JAL_T       = 32'h0C000010;
  localparam logic [31:0] SW_4_0_1    = 32'hAC240000;
  localparam logic [31:0] JR_31       = 32'h03E00008;
  localparam logic [31:0] LW_4_0_1    = 32'h8C240000;
  localparam logic [31:0] ADD_7_4_2   = 32'h00823820;
  localparam logic [31:0] LW_0_0_1    = 32'h8C200000;
  localparam logic [31:0] ADD_7_0_2   = 32'h00023820;
  localparam logic [31:0] ADDI_4_1_1  = 32'h20240001;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
    .rs_data(rs_data), .rt_data(rt_data), .hold(hold), .flush(flush),
    .ID_EX_inst(ID_EX_inst), .Rd_ID_EX(Rd_ID_EX), .id_ex_pc(id_ex_pc),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm), .id_ex_valid(id_ex_valid), .load_use_stall(load_use_stall)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    if_id_inst = ADD_3_1_2; if_id_pc = 32'h104; rs_data = 32'h11; rt_data = 32'h22;
    tick; tick;
    checks++;
    if ({ID_EX_inst, Rd_ID_EX, id_ex_valid, load_use_stall} !== {32'h0, 5'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_state: inst=%h rd=%0d valid=%b stall=%b, want 0/0/0/0",
                        ID_EX_inst, Rd_ID_EX, id_ex_valid, load_use_stall);
    end
    checks++;
    if ({id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm} !== 128'h0) begin
      fails++; $display("FAIL reset_data: pc=%h rs=%h rt=%h imm=%h, want all 0",
                        id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm);
    end
    rst = 1'b0;
    tick;
    checks++;
    if ({Rd_ID_EX, id_ex_valid, ID_EX_inst} !== {5'd3, 1'b1, ADD_3_1_2}) begin
      fails++; $display("FAIL first_load: rd=%0d valid=%b inst=%h, want 3/1/%h",
                        Rd_ID_EX, id_ex_valid, ID_EX_inst, ADD_3_1_2);
    end
    checks++;
    if ({id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm} !== {32'h104, 32'h11, 32'h22, 32'h00001820}) begin
      fails++; $display("FAIL first_load_data: pc=%h rs=%h rt=%h imm=%h, want 104/11/22/1820",
                        id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm);
    end
  endtask

  task automatic test_decode;
    logic [31:0] inst, eimm;
    logic [4:0]  erd;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin inst = ADDI_5_0_M1; erd = 5'd5;  eimm = 32'hFFFFFFFF; end
        1: begin inst = ORI_6_0_FF;  erd = 5'd6;  eimm = 32'h0000FFFF; end
        2: begin inst = JAL_T;       erd = 5'd31; eimm = 32'h00000010; end
        3: begin inst = SW_4_0_1;    erd = 5'd0;  eimm = 32'h00000000; end
        default: begin inst = JR_31; erd = 5'd0;  eimm = 32'h00000008; end
      endcase
      if_id_inst = inst;
      tick;
      checks++;
      if ({Rd_ID_EX, id_ex_imm, id_ex_valid} !== {erd, eimm, 1'b1}) begin
        fails++; $display("FAIL decode_%0d: rd=%0d imm=%h valid=%b, want %0d/%h/1",
                          i, Rd_ID_EX, id_ex_imm, id_ex_valid, erd, eimm);
      end
    end
  endtask

  task automatic test_load_use;
    // lw $4 followed by add reading $4 as rs
    if_id_inst = LW_4_0_1; tick;
    if_id_inst = ADD_7_4_2; #1;
    checks++;
    if (load_use_stall !== 1'b1) begin
      fails++; $display("FAIL lu_add_stall: stall=%b, want 1", load_use_stall);
    end
    tick;
    checks++;
    if ({id_ex_valid, Rd_ID_EX, ID_EX_inst, load_use_stall} !== {1'b0, 5'd0, 32'h0, 1'b0}) begin
      fails++; $display("FAIL lu_bubble: valid=%b rd=%0d inst=%h stall=%b, want 0/0/0/0",
                        id_ex_valid, Rd_ID_EX, ID_EX_inst, load_use_stall);
    end
    tick;
    checks++;
    if ({id_ex_valid, Rd_ID_EX} !== {1'b1, 5'd7}) begin
      fails++; $display("FAIL lu_after: valid=%b rd=%0d, want 1/7", id_ex_valid, Rd_ID_EX);
    end
    // sw reading $4 as rt also stalls
    if_id_inst = LW_4_0_1; tick;
    if_id_inst = SW_4_0_1; #1;
    checks++;
    if (load_use_stall !== 1'b1) begin
      fails++; $display("FAIL lu_sw_stall: stall=%b, want 1", load_use_stall);
    end
    tick; tick;
    // lw $0 never stalls, even when ID reads $0
    if_id_inst = LW_0_0_1; tick;
    if_id_inst = ADD_7_0_2; #1;
    checks++;
    if (load_use_stall !== 1'b0) begin
      fails++; $display("FAIL lu_r0: stall=%b, want 0", load_use_stall);
    end
    // addi writes rt=$4 but does not read it
    if_id_inst = LW_4_0_1; tick;
    if_id_inst = ADDI_4_1_1; #1;
    checks++;
    if (load_use_stall !== 1'b0) begin
      fails++; $display("FAIL lu_itype_rt: stall=%b, want 0", load_use_stall);
    end
    tick;
  endtask

  task automatic test_hold;
    if_id_inst = ADD_3_1_2; if_id_pc = 32'h200; rs_data = 32'hA; rt_data = 32'hB; tick;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_id_inst = (i == 0) ? ADDI_5_0_M1 : (i == 1) ? ORI_6_0_FF : JAL_T;
      if_id_pc = 32'h300 + i; rs_data = 32'h55; rt_data = 32'h66;
      tick;
      checks++;
      if ({ID_EX_inst, Rd_ID_EX, id_ex_valid, id_ex_pc, id_ex_rs_data, id_ex_rt_data} !==
          {ADD_3_1_2, 5'd3, 1'b1, 32'h200, 32'hA, 32'hB}) begin
        fails++; $display("FAIL hold_%0d: inst=%h rd=%0d valid=%b pc=%h rs=%h rt=%h, want frozen add",
                          i, ID_EX_inst, Rd_ID_EX, id_ex_valid, id_ex_pc, id_ex_rs_data, id_ex_rt_data);
      end
    end
    hold = 1'b0;
    // hold plus load-use: freeze, stall persists
    if_id_inst = LW_4_0_1; tick;
    hold = 1'b1; if_id_inst = ADD_7_4_2;
    tick; tick;
    checks++;
    if ({ID_EX_inst, id_ex_valid, load_use_stall} !== {LW_4_0_1, 1'b1, 1'b1}) begin
      fails++; $display("FAIL hold_lu: inst=%h valid=%b stall=%b, want lw/1/1",
                        ID_EX_inst, id_ex_valid, load_use_stall);
    end
    hold = 1'b0; tick;
    checks++;
    if (id_ex_valid !== 1'b0) begin
      fails++; $display("FAIL hold_lu_bubble: valid=%b, want 0", id_ex_valid);
    end
    tick;
    checks++;
    if (Rd_ID_EX !== 5'd7) begin
      fails++; $display("FAIL hold_lu_after: rd=%0d, want 7", Rd_ID_EX);
    end
  endtask

  task automatic test_flush;
    if_id_inst = ADD_3_1_2; tick;
    flush = 1'b1; hold = 1'b1; if_id_inst = ADDI_5_0_M1;
    tick;
    checks++;
    if ({id_ex_valid, Rd_ID_EX, ID_EX_inst, id_ex_pc, id_ex_imm} !== {1'b0, 5'd0, 32'h0, 32'h0, 32'h0}) begin
      fails++; $display("FAIL flush_hold: valid=%b rd=%0d inst=%h pc=%h imm=%h, want bubble",
                        id_ex_valid, Rd_ID_EX, ID_EX_inst, id_ex_pc, id_ex_imm);
    end
    flush = 1'b0; hold = 1'b0;
    // flush with a pending load-use
    if_id_inst = LW_4_0_1; tick;
    if_id_inst = ADD_7_4_2; flush = 1'b1; tick;
    flush = 1'b0; #1;
    checks++;
    if ({id_ex_valid, load_use_stall} !== 2'b00) begin
      fails++; $display("FAIL flush_lu: valid=%b stall=%b, want 0/0", id_ex_valid, load_use_stall);
    end
    tick;
    checks++;
    if ({id_ex_valid, Rd_ID_EX} !== {1'b1, 5'd7}) begin
      fails++; $display("FAIL flush_lu_after: valid=%b rd=%0d, want 1/7", id_ex_valid, Rd_ID_EX);
    end
    // reset mid-operation discards the lw in flight
    if_id_inst = LW_4_0_1; tick;
    rst = 1'b1; if_id_inst = ADD_7_4_2; tick;
    checks++;
    if ({id_ex_valid, Rd_ID_EX, load_use_stall} !== {1'b0, 5'd0, 1'b0}) begin
      fails++; $display("FAIL reset_mid: valid=%b rd=%0d stall=%b, want 0/0/0",
                        id_ex_valid, Rd_ID_EX, load_use_stall);
    end
    rst = 1'b0;
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_perf;
    rst = 1'b1; hold = 1'b0; flush = 1'b0; tick; rst = 1'b0;
    if_id_inst = LW_4_0_1; tick;
    if_id_inst = ADD_7_4_2; tick;
    tick;
    flush = 1'b1; tick; flush = 1'b0;
    hold = 1'b1; tick; tick; tick; hold = 1'b0;
    checks++;
    if ({bubble_cnt, hold_cnt} !== {32'd2, 32'd3}) begin
      fails++; $display("FAIL perf_cnt: bubble=%0d hold=%0d, want 2/3", bubble_cnt, hold_cnt);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_decode;
    test_load_use;
    test_hold;
    test_flush;
`ifdef ID_EX_PERF_CNT_EN
    test_perf;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline; sits directly upstream of the forwarding/hazard control.
- Captures the decoded instruction, operands and immediate from ID, and produces the ID_EX_inst and Rd_ID_EX values that the forwarding logic compares against.
- Detects load-use hazards, inserts bubbles, and honours external hold and flush requests.

Parameters:
- NOP_INST, 32'h00000000, encoding loaded on bubble/flush/reset (sll $0,$0,0)
- LINK_REG, 5'd31, destination register written by jal

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- if_id_inst  input  32  instruction currently in ID
- if_id_pc  input  32  PC+4 of the instruction in ID
- rs_data  input  32  register-file read port A (rs)
- rt_data  input  32  register-file read port B (rt)
- hold  input  1  external freeze (e.g. memory wait); register keeps its contents
- flush  input  1  branch/jump squash; ID/EX becomes a bubble
- ID_EX_inst  output  32  registered instruction
- Rd_ID_EX  output  5  registered destination register (0 = no write)
- id_ex_pc  output  32  registered PC+4
- id_ex_rs_data  output  32  registered rs operand
- id_ex_rt_data  output  32  registered rt operand
- id_ex_imm  output  32  registered extended immediate
- id_ex_valid  output  1  1 = real instruction, 0 = bubble
- load_use_stall  output  1  combinational; upstream must hold the PC and IF/ID register this cycle

Behaviour:
- Reset (rst=1 at clock edge):
  - ID_EX_inst=NOP_INST; Rd_ID_EX=0; pc, operands and imm = 0; id_ex_valid=0.
  - load_use_stall therefore reads 0 in the cycle after reset.
  - Reset mid-operation discards the in-flight instruction; no partial state is kept.
- Per-edge priority:
  1. rst
  2. flush → bubble
  3. hold → all registers keep their value
  4. load_use_stall → bubble
  5. otherwise load from ID
- Bubble: ID_EX_inst=NOP_INST, Rd_ID_EX=0, id_ex_valid=0; pc, operands and imm = 0.
- Load: latency is 1 cycle. All outputs reflect the ID inputs sampled at the edge, and id_ex_valid=1.
- Rd decode, from if_id_inst at load time:
  - opcode 000000: rd = inst[15:11]. Exception: funct 001000 (jr) gives 0.
  - lw 100011, addi 001000, addiu 001001, slti 001010, andi 001100, ori 001101, lui 001111: rt = inst[20:16].
  - jal 000011: LINK_REG.
  - All others (sw, beq, bne, j, unknown): 0.
- Immediate:
  - andi and ori: zero-extend inst[15:0].
  - All other opcodes: sign-extend inst[15:0].
  - No shift is applied for lui; EX handles that.
- load_use_stall is 1 only when all of the following hold:
  - id_ex_valid=1
  - ID_EX_inst[31:26]=100011
  - Rd_ID_EX!=0
  - Rd_ID_EX equals if_id_inst[25:21], or equals if_id_inst[20:16] when the ID instruction reads rt. Instructions that read rt are R-type, sw, beq and bne.
- load_use_stall depends only on the registered state and if_id_inst, never on hold or flush.
- A load-use stall lasts exactly one cycle: the bubble clears id_ex_valid, which drops the condition.
- Simultaneous events:
  - flush with hold: bubble.
  - hold with load-use: freeze, no bubble; the stall persists until hold drops.
  - flush with load-use: bubble, and upstream flush has precedence.
- $0 is never reported as a destination, so the forwarding logic never matches register 0.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined, adds two outputs, each a 32-bit saturating counter that resets to 0 on rst:
  - bubble_cnt: incremented on each edge where a bubble is loaded because of load-use or flush.
  - hold_cnt: incremented on each edge where hold freezes the register.
- When undefined, neither the ports nor the logic exist, and the block is otherwise bit-identical.

Test Plan:
- Reset: assert rst for 2 cycles with if_id_inst=add $3,$1,$2 → ID_EX_inst=0, Rd_ID_EX=0, id_ex_valid=0, load_use_stall=0. First edge after release loads Rd_ID_EX=3, id_ex_valid=1.
- Rd/imm decode: addi $5,$0,-1 → Rd_ID_EX=5, id_ex_imm=32'hFFFFFFFF. ori $6,$0,0xFFFF → imm=32'h0000FFFF. jal → Rd=31. sw → Rd=0. jr $31 → Rd=0.
- Load-use: lw $4,0($1) in ID/EX, add $7,$4,$2 in ID → load_use_stall=1. Next edge: bubble (valid=0, Rd=0), stall=0. Following edge: add loads with Rd_ID_EX=7. The same case with sw $4,0($1) in ID also stalls; with lw $0 it does not.
- Hold: with valid add in ID/EX, hold=1 for 3 cycles while if_id_inst changes → all outputs unchanged. Hold plus a load-use condition → no bubble until hold=0.
- Flush: flush=1 with hold=1 and valid input → bubble on that edge, id_ex_valid=0.
- With ID_EX_PERF_CNT_EN: one load-use, one flush and 3 hold cycles → bubble_cnt=2, hold_cnt=3. Counter preloaded to 32'hFFFFFFFF stays saturated.
